sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbitrates the single-port data SRAM between the instruction-fetch port (read-only) and the load/store port of the RV32I pipeline. Each port sends requests with a req/gnt handshake. The block latches one granted transaction, drives the SRAM macro's active-low control pins for exactly one cycle, and waits the fixed read latency. It then returns an ack pulse with read data. Data-port requests win ties, and a starvation counter guarantees forward progress for instruction fetch.

## Interface
- RD_LAT, 1: SRAM cycles from the access edge to valid dout; legal range 1..7.
- STARVE_MAX, 4: consecutive data-port grants allowed while an instruction request is pending; legal range 1..15.
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- i_req_i  in  1  instruction-port read request; held with address until i_gnt_o.
- i_addr_i  in  12  instruction word address.
- i_gnt_o  out  1  instruction request accepted this cycle (combinational).
- i_ack_o  out  1  instruction read data valid on rdata_o this cycle.
- d_req_i  in  1  data-port request; held with all fields until d_gnt_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  12  data word address.
- d_wdata_i  in  32  write data.
- d_wmask_i  in  4  byte-lane write mask; bit n enables byte n.
- d_gnt_o  out  1  data request accepted this cycle (combinational).
- d_ack_o  out  1  data transaction complete; for reads, rdata_o is valid.
- rdata_o  out  32  read data; passthrough of sram_rdata_i when an ack is high, else 0.
- sram_csb_o  out  1  SRAM chip select, active-low (registered).
- sram_web_o  out  1  SRAM write enable, active-low (registered).
- sram_wmask_o  out  4  SRAM write mask (registered).
- sram_addr_o  out  12  SRAM address (registered).
- sram_wdata_o  out  32  SRAM write data (registered).
- sram_rdata_i  in  32  SRAM dout.

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- **IDLE**
  - If any req is high, grant one requester and go to ACCESS.
  - Latch addr, we, wdata and wmask into the sram_* output registers.
  - Set csb to 0.
  - Set web to the inverse of we; it is always 1 for the instruction port.
  - Record the owner.
- **ACCESS** (exactly 1 cycle)
  - sram_csb_o = 0 and the command is presented to the SRAM.
  - On exit, csb returns to 1, web to 1, and mask to 0.
  - Go to WAIT with the wait counter at RD_LAT-1.
- **WAIT**
  - Decrement the counter each cycle.
  - The cycle in which the counter is 0 is the ack cycle: the owner's ack_o is high.
    - For reads, rdata_o = sram_rdata_i.
    - For writes, rdata_o = 0.
  - In the ack cycle, the arbiter may grant a new request, with the same rules as IDLE, and go to ACCESS. Otherwise it goes to IDLE.
- **Arbitration**
  - Only d_req: data wins.
  - Only i_req: instruction wins.
  - Both requests, starve counter < STARVE_MAX: data wins.
  - Both requests, starve counter = STARVE_MAX: instruction wins.
- **Starve counter** (4 bits)
  - Increments on a data grant while i_req_i is high.
  - Clears on an instruction grant, and in any cycle where i_req_i is low.
  - Saturates at STARVE_MAX.
- At most one gnt_o is high per cycle. Grants occur only in IDLE or in the ack cycle.
- Only one transaction is in flight; there is no queuing.
- A request dropped before its grant is a requester protocol violation and is not checked.

## Timing
- **Reset values:**
  - sram_csb_o = 1, sram_web_o = 1.
  - sram_wmask_o = 0, sram_addr_o = 0, sram_wdata_o = 0.
  - All gnt/ack outputs = 0, rdata_o = 0.
  - State IDLE; starve and wait counters = 0.
- **Grant at cycle T:**
  - sram_csb_o is low during T+1.
  - The ack is high during T+1+RD_LAT.
  - Next grant no earlier than T+1+RD_LAT, so peak throughput is one transaction per RD_LAT+1 cycles.
- gnt_o is combinational from req, state and counters.
- ack_o is decoded from registered state.
- **Asynchronous reset mid-transaction:**
  - Outputs return to their reset values immediately.
  - The in-flight transaction is abandoned with no ack.
  - A write already sampled by the SRAM may have completed.
- **Address wrap:** addresses are 12-bit and pass through unmodified; 0xFFF is legal. No address arithmetic is performed.

## Test plan
- **Reset:** assert rst_ni=0 mid-WAIT of a read.
  - csb/web read 1 immediately and no ack is emitted.
  - After release, i_req with addr 0x010 is granted in the first cycle.
- **Single read** (RD_LAT=1): d_req read at 0x004, with the SRAM returning 0xDEADBEEF.
  - d_gnt_o at T, csb low only at T+1.
  - d_ack_o at T+2 with rdata_o=0xDEADBEEF.
- **Write:** d_we=1, addr 0xFFF, wdata 0x12345678, wmask 0b0101.
  - At T+1: sram_web_o=0, wmask=0101, addr=0xFFF.
  - d_ack_o at T+2 with rdata_o=0.
- **Back-to-back:** i_req held continuously.
  - Grants at T, T+2, T+4, with acks at T+2, T+4, T+6.
- **Starvation** (STARVE_MAX=4): d_req and i_req held continuously.
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
- **Simultaneous requests at RD_LAT=3:** both req in IDLE.
  - d_gnt first; its ack at T+4.
  - i_gnt in the same ack cycle, with csb low at T+5.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port data SRAM between instruction fetch and load/store
module sram_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req_i,
    input  logic [11:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_ack_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [11:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wmask_i,
    output logic        d_gnt_o,
    output logic        d_ack_o,
    output logic [31:0] rdata_o,
    output logic        sram_csb_o,
    output logic        sram_web_o,
    output logic [3:0]  sram_wmask_o,
    output logic [11:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_cnt;
    logic [3:0]  r_starve;
    logic        r_own_d, r_we;
    logic        r_csb, r_web;
    logic [3:0]  r_wmask;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_ack, w_can_gnt, w_pick_i, w_i_gnt, w_d_gnt, w_gnt;

    // Arbitration and next state; data wins ties until instruction fetch has waited STARVE_MAX grants
    always_comb begin
        w_ack     = (r_state == WAIT) && (r_cnt == 3'd0);
        w_can_gnt = (r_state == IDLE) || w_ack;
        w_pick_i  = i_req_i && (!d_req_i || r_starve == 4'(STARVE_MAX));
        w_i_gnt   = w_can_gnt && w_pick_i;
        w_d_gnt   = w_can_gnt && d_req_i && !w_pick_i;
        w_gnt     = w_i_gnt || w_d_gnt;
        w_next    = r_state;
        case (r_state)
            IDLE:    w_next = w_gnt ? ACCESS : IDLE;
            ACCESS:  w_next = WAIT;
            WAIT:    w_next = w_ack ? (w_gnt ? ACCESS : IDLE) : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // SRAM command registers: loaded on grant, returned to inactive after the single access cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_own_d <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_gnt) begin
            r_csb   <= 1'b0;
            r_web   <= ~(w_d_gnt && d_we_i);
            r_wmask <= w_d_gnt ? d_wmask_i : '0;
            r_addr  <= w_d_gnt ? d_addr_i : i_addr_i;
            r_wdata <= w_d_gnt ? d_wdata_i : '0;
            r_own_d <= w_d_gnt;
            r_we    <= w_d_gnt && d_we_i;
        end else if (r_state == ACCESS) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
        end
    end

    // Read-latency countdown; zero in WAIT marks the ack cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          r_cnt <= '0;
        else if (r_state == ACCESS)           r_cnt <= 3'(RD_LAT - 1);
        else if (r_state == WAIT && r_cnt != 0) r_cnt <= r_cnt - 3'd1;
    end

    // Starvation counter: counts data grants that bypassed a pending instruction request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                           r_starve <= '0;
        else if (!i_req_i || w_i_gnt)                          r_starve <= '0;
        else if (w_d_gnt && r_starve != 4'(STARVE_MAX))        r_starve <= r_starve + 4'd1;
    end

    assign i_gnt_o      = w_i_gnt;
    assign d_gnt_o      = w_d_gnt;
    assign i_ack_o      = w_ack && !r_own_d;
    assign d_ack_o      = w_ack && r_own_d;
    assign rdata_o      = (w_ack && !r_we) ? sram_rdata_i : '0;
    assign sram_csb_o   = r_csb;
    assign sram_web_o   = r_web;
    assign sram_wmask_o = r_wmask;
    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = r_wdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter at RD_LAT=1 and RD_LAT=3
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic        a_i_req, a_i_gnt, a_i_ack, a_d_req, a_d_we, a_d_gnt, a_d_ack, a_csb, a_web;
    logic [11:0] a_i_addr, a_d_addr, a_addr;
    logic [31:0] a_d_wdata, a_rdata, a_wdata, a_srd;
    logic [3:0]  a_d_wmask, a_wmask;

    logic        b_i_req, b_i_gnt, b_i_ack, b_d_req, b_d_we, b_d_gnt, b_d_ack, b_csb, b_web;
    logic [11:0] b_i_addr, b_d_addr, b_addr;
    logic [31:0] b_d_wdata, b_rdata, b_wdata, b_srd;
    logic [3:0]  b_d_wmask, b_wmask;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(a_i_req), .i_addr_i(a_i_addr), .i_gnt_o(a_i_gnt), .i_ack_o(a_i_ack),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
        .d_wmask_i(a_d_wmask), .d_gnt_o(a_d_gnt), .d_ack_o(a_d_ack), .rdata_o(a_rdata),
        .sram_csb_o(a_csb), .sram_web_o(a_web), .sram_wmask_o(a_wmask), .sram_addr_o(a_addr),
        .sram_wdata_o(a_wdata), .sram_rdata_i(a_srd)
    );

    sram_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(b_i_req), .i_addr_i(b_i_addr), .i_gnt_o(b_i_gnt), .i_ack_o(b_i_ack),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_wmask_i(b_d_wmask), .d_gnt_o(b_d_gnt), .d_ack_o(b_d_ack), .rdata_o(b_rdata),
        .sram_csb_o(b_csb), .sram_web_o(b_web), .sram_wmask_o(b_wmask), .sram_addr_o(b_addr),
        .sram_wdata_o(b_wdata), .sram_rdata_i(b_srd)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
        {a_i_addr, a_d_addr, b_i_addr, b_d_addr} = '0;
        {a_d_wdata, b_d_wdata} = '0;
        {a_d_wmask, b_d_wmask} = '0;
        a_srd = 32'hDEADBEEF;
        b_srd = 32'hCAFEF00D;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_csb", a_csb, 1'b1);
        chk1("rst_web", a_web, 1'b1);
        chk32("rst_wmask", 32'(a_wmask), 32'h0);
        chk32("rst_addr", 32'(a_addr), 32'h0);
        chk32("rst_wdata", a_wdata, 32'h0);
        chk1("rst_ack", a_d_ack | a_i_ack, 1'b0);
        chk32("rst_rdata", a_rdata, 32'h0);
        chk1("rst_b_csb", b_csb, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // single read, RD_LAT=1
        @(negedge clk);
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 12'h004;
        #1;
        chk1("rd_gnt", a_d_gnt, 1'b1);
        chk1("rd_igant", a_i_gnt, 1'b0);
        chk1("rd_csb_t0", a_csb, 1'b1);
        @(negedge clk);
        a_d_req = 1'b0;
        #1;
        chk1("rd_csb_t1", a_csb, 1'b0);
        chk1("rd_web_t1", a_web, 1'b1);
        chk32("rd_addr_t1", 32'(a_addr), 32'h004);
        chk1("rd_ack_t1", a_d_ack, 1'b0);
        @(negedge clk);
        #1;
        chk1("rd_ack_t2", a_d_ack, 1'b1);
        chk32("rd_data_t2", a_rdata, 32'hDEADBEEF);
        chk1("rd_csb_t2", a_csb, 1'b1);
        @(negedge clk);
        #1;
        chk1("rd_ack_t3", a_d_ack, 1'b0);
        chk32("rd_data_t3", a_rdata, 32'h0);

        // write to top address
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 12'hFFF; a_d_wdata = 32'h12345678; a_d_wmask = 4'b0101;
        #1;
        chk1("wr_gnt", a_d_gnt, 1'b1);
        @(negedge clk);
        a_d_req = 1'b0; a_d_we = 1'b0;
        #1;
        chk1("wr_csb_t1", a_csb, 1'b0);
        chk1("wr_web_t1", a_web, 1'b0);
        chk32("wr_wmask_t1", 32'(a_wmask), 32'h5);
        chk32("wr_addr_t1", 32'(a_addr), 32'hFFF);
        chk32("wr_wdata_t1", a_wdata, 32'h12345678);
        @(negedge clk);
        #1;
        chk1("wr_ack_t2", a_d_ack, 1'b1);
        chk32("wr_rdata_t2", a_rdata, 32'h0);
        chk1("wr_web_t2", a_web, 1'b1);
        chk32("wr_wmask_t2", 32'(a_wmask), 32'h0);
        @(negedge clk);

        // back-to-back instruction fetches
        a_i_req = 1'b1; a_i_addr = 12'h020;
        #1;
        chk1("b2b_gnt_t0", a_i_gnt, 1'b1);
        @(negedge clk);
        #1;
        chk1("b2b_gnt_t1", a_i_gnt, 1'b0);
        chk1("b2b_csb_t1", a_csb, 1'b0);
        chk32("b2b_addr_t1", 32'(a_addr), 32'h020);
        @(negedge clk);
        #1;
        chk1("b2b_ack_t2", a_i_ack, 1'b1);
        chk1("b2b_gnt_t2", a_i_gnt, 1'b1);
        chk32("b2b_data_t2", a_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk1("b2b_ack_t3", a_i_ack, 1'b0);
        @(negedge clk);
        #1;
        chk1("b2b_ack_t4", a_i_ack, 1'b1);
        chk1("b2b_gnt_t4", a_i_gnt, 1'b1);
        @(negedge clk);
        a_i_req = 1'b0;
        @(negedge clk);
        #1;
        chk1("b2b_ack_t6", a_i_ack, 1'b1);
        chk1("b2b_gnt_t6", a_i_gnt, 1'b0);
        @(negedge clk);

        // starvation: expected grants D,D,D,D,I,D,D,D,D,I
        a_d_req = 1'b1; a_d_addr = 12'h200; a_i_req = 1'b1; a_i_addr = 12'h300;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk1($sformatf("starve_d%0d", k), a_d_gnt, (k % 5) != 4);
            chk1($sformatf("starve_i%0d", k), a_i_gnt, (k % 5) == 4);
            @(negedge clk);
            #1;
            chk1($sformatf("starve_acc%0d", k), a_d_gnt | a_i_gnt, 1'b0);
            @(negedge clk);
        end
        a_d_req = 1'b0; a_i_req = 1'b0;
        #1;
        chk1("starve_last_iack", a_i_ack, 1'b1);
        @(negedge clk);

        // simultaneous requests at RD_LAT=3
        b_d_req = 1'b1; b_d_addr = 12'h040; b_i_req = 1'b1; b_i_addr = 12'h030;
        #1;
        chk1("sim_dgnt_t0", b_d_gnt, 1'b1);
        chk1("sim_igntt0", b_i_gnt, 1'b0);
        @(negedge clk);
        b_d_req = 1'b0;
        #1;
        chk1("sim_csb_t1", b_csb, 1'b0);
        chk32("sim_addr_t1", 32'(b_addr), 32'h040);
        @(negedge clk);
        #1;
        chk1("sim_ack_t2", b_d_ack, 1'b0);
        chk1("sim_ignt_t2", b_i_gnt, 1'b0);
        @(negedge clk);
        #1;
        chk1("sim_ack_t3", b_d_ack, 1'b0);
        @(negedge clk);
        #1;
        chk1("sim_ack_t4", b_d_ack, 1'b1);
        chk1("sim_ignt_t4", b_i_gnt, 1'b1);
        chk32("sim_data_t4", b_rdata, 32'hCAFEF00D);
        @(negedge clk);
        b_i_req = 1'b0;
        #1;
        chk1("sim_csb_t5", b_csb, 1'b0);
        chk32("sim_addr_t5", 32'(b_addr), 32'h030);
        chk1("sim_web_t5", b_web, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk1("sim_iack_t8", b_i_ack, 1'b1);
        chk32("sim_idata_t8", b_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // asynchronous reset in the middle of a read's wait
        b_d_req = 1'b1; b_d_addr = 12'h050;
        #1;
        chk1("ar_gnt", b_d_gnt, 1'b1);
        @(negedge clk);
        b_d_req = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("ar_addr", 32'(b_addr), 32'h0);
        chk1("ar_csb", b_csb, 1'b1);
        chk1("ar_web", b_web, 1'b1);
        @(negedge clk);
        #1;
        chk1("ar_ack_t3", b_d_ack, 1'b0);
        @(negedge clk);
        #1;
        chk1("ar_ack_t4", b_d_ack, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        b_i_req = 1'b1; b_i_addr = 12'h010;
        #1;
        chk1("ar_ack_t5", b_d_ack, 1'b0);
        chk1("ar_ignt", b_i_gnt, 1'b1);
        @(negedge clk);
        b_i_req = 1'b0;
        #1;
        chk1("ar_csb_after", b_csb, 1'b0);
        chk32("ar_addr_after", 32'(b_addr), 32'h010);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
